// File: rtl/snes_pad_responder.sv
// snes_pad_responder: controller end of the SNES/NES serial pad link.
// Snapshots the button word while the console holds LATCH, then presents one
// bit per console CLK rising edge on pad_data. Console pins are asynchronous
// and pass through synchronizers into the core clock domain.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no frame in progress, line parked high
// LATCHED | latch held, snapshot tracks buttons every cycle
// SHIFT   | latch released, one bit presented per pad_clk rise
// TAIL    | all N_BITS shifted out, line held at TAIL_LEVEL until next latch

module snes_pad_responder #(
    parameter int   SYNC_STAGES    = 2,
    parameter int   N_BITS         = 16,
    parameter logic TAIL_LEVEL     = 1'b0,
    parameter int   TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] buttons,
    input  logic        pad_latch,
    input  logic        pad_clk,
    output logic        pad_data,
    output logic        frame_done,
    output logic        active
);

    localparam int CW = $clog2(N_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        SHIFT   = 2'd2,
        TAIL    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_d;
    logic                   clk_d;
    logic                   latch_s;
    logic                   latch_fall;
    logic                   clk_rise;

    state_t                 state_q, state_n;
    // Bit 0 of the frame lives in pad_data_q itself; sr holds the bits still
    // waiting to be presented, so the line is always a plain flop output.
    logic [N_BITS-1:1]      sr_q, sr_n;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_n;
    logic [TW-1:0]          tcnt_q, tcnt_n;
    logic                   pad_data_q, pad_data_n;
    logic                   frame_done_q, frame_done_n;
    logic [N_BITS-1:0]      load_word;

    // Synchronize console pins; reset to their idle levels so no false edge
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_sync <= '0;
            clk_sync   <= '1;
            latch_d    <= 1'b0;
            clk_d      <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], pad_clk};
            latch_d    <= latch_sync[SYNC_STAGES-1];
            clk_d      <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign latch_fall = ~latch_s & latch_d;
    assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_d;

    // Line levels for a fresh frame: ID bits read as 1, buttons active-low
    always_comb begin
        load_word       = '1;
        load_word[11:0] = ~buttons;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '1;
            bit_cnt_q    <= '0;
            tcnt_q       <= '0;
            pad_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            sr_q         <= sr_n;
            bit_cnt_q    <= bit_cnt_n;
            tcnt_q       <= tcnt_n;
            pad_data_q   <= pad_data_n;
            frame_done_q <= frame_done_n;
        end
    end

    // Next-state and datapath logic; latch overrides everything, including a
    // coincident pad_clk rise
    always_comb begin
        state_n      = state_q;
        sr_n         = sr_q;
        bit_cnt_n    = bit_cnt_q;
        tcnt_n       = tcnt_q;
        pad_data_n   = pad_data_q;
        frame_done_n = 1'b0;

        if (latch_s) begin
            state_n    = LATCHED;
            sr_n       = load_word[N_BITS-1:1];
            pad_data_n = load_word[0];
            bit_cnt_n  = '0;
            tcnt_n     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pad_data_n = 1'b1;
                end
                LATCHED: begin
                    if (latch_fall) begin
                        state_n = SHIFT;
                        tcnt_n  = '0;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        sr_n      = {TAIL_LEVEL, sr_q[N_BITS-1:2]};
                        bit_cnt_n = bit_cnt_q + CW'(1);
                        tcnt_n    = '0;
                        if (bit_cnt_q == CW'(N_BITS - 1)) begin
                            state_n      = TAIL;
                            pad_data_n   = TAIL_LEVEL;
                            frame_done_n = 1'b1;
                        end else begin
                            pad_data_n = sr_q[1];
                        end
                    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Console went away mid-frame; park the line
                        state_n    = IDLE;
                        pad_data_n = 1'b1;
                    end else if (tcnt_q != '1) begin
                        tcnt_n = tcnt_q + TW'(1);
                    end
                end
                TAIL: begin
                    pad_data_n = TAIL_LEVEL;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign pad_data   = pad_data_q;
    assign frame_done = frame_done_q;
    assign active     = (state_q != IDLE);

endmodule
